// File: rtl/memory_controller.sv
// memory_controller
//
// Dual-region video memory for the text-mode GPU path. A single write port
// with a unified 16-bit address space feeds two block RAMs: the character
// RAM (2**CHAR_AW words at 0x0000) and the font RAM (2**FONT_AW words at
// FONT_BASE). Two independent synchronous read ports, one per RAM, serve the
// character fetcher and the glyph fetcher.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset (clears read outputs only)
//   addrW      in   unified write address; a write is attempted every edge
//   dataW      in   write data
//   addrRChar  in   character RAM read address
//   addrRFont  in   font RAM read address
//   dataChar   out  character RAM read data
//   dataFont   out  font RAM read data
//
// Build option
//   MEMCTRL_OUTREG_EN  adds a second, resettable output register on both
//                      read ports (read latency 2 instead of 1).
//
// Addresses outside both regions (hosts park at 0xFFFF) write nothing.
// Reads are read-first: a read of the location being written in the same
// cycle returns the previous contents.

module memory_controller #(
    parameter int          DW        = 8,
    parameter int          CHAR_AW   = 13,
    parameter int          FONT_AW   = 12,
    parameter logic [15:0] FONT_BASE = 16'h2000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        addrW,
    input  logic [DW-1:0]      dataW,
    input  logic [CHAR_AW-1:0] addrRChar,
    input  logic [FONT_AW-1:0] addrRFont,
    output logic [DW-1:0]      dataChar,
    output logic [DW-1:0]      dataFont
);

    localparam int unsigned CHAR_WORDS = 32'd1 << CHAR_AW;
    localparam int unsigned FONT_WORDS = 32'd1 << FONT_AW;
    localparam int unsigned FONT_LO    = 32'(FONT_BASE);
    localparam int unsigned FONT_HI    = FONT_LO + FONT_WORDS;

    // Power-up contents are zero; reset deliberately leaves them alone.
    logic [DW-1:0] charMem [CHAR_WORDS] = '{default: '0};
    logic [DW-1:0] fontMem [FONT_WORDS] = '{default: '0};

    logic [31:0]        addrWide;
    logic               charHit;
    logic               fontHit;
    logic [CHAR_AW-1:0] charAddrW;
    logic [FONT_AW-1:0] fontAddrW;

    logic [DW-1:0]      charRd;
    logic [DW-1:0]      fontRd;

    // Write decode: compare the full 16-bit address so that parked or
    // unmapped addresses never alias into either RAM.
    always_comb begin
        addrWide  = 32'(addrW);
        charHit   = addrWide < CHAR_WORDS;
        fontHit   = (addrWide >= FONT_LO) && (addrWide < FONT_HI);
        charAddrW = addrW[CHAR_AW-1:0];
        fontAddrW = FONT_AW'(addrW - FONT_BASE);
    end

    // RAM write ports. Kept out of the reset block so the arrays stay plain
    // block RAM; rst only gates the write strobe.
    always_ff @(posedge clk) begin
        if (!rst && charHit) begin
            charMem[charAddrW] <= dataW;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fontHit) begin
            fontMem[fontAddrW] <= dataW;
        end
    end

    // RAM read stage. Non-blocking update against the write blocks above
    // gives read-first behaviour on a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            charRd <= '0;
            fontRd <= '0;
        end else begin
            charRd <= charMem[addrRChar];
            fontRd <= fontMem[addrRFont];
        end
    end

`ifdef MEMCTRL_OUTREG_EN
    logic [DW-1:0] charOut;
    logic [DW-1:0] fontOut;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            charOut <= '0;
            fontOut <= '0;
        end else begin
            charOut <= charRd;
            fontOut <= fontRd;
        end
    end

    assign dataChar = charOut;
    assign dataFont = fontOut;
`else
    assign dataChar = charRd;
    assign dataFont = fontRd;
`endif

endmodule

// File: tb/tb_memory_controller.sv
module tb_memory_controller;

`ifdef MEMCTRL_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addrW;
    logic [7:0]  dataW;
    logic [12:0] addrRChar;
    logic [11:0] addrRFont;
    logic [7:0]  dataChar;
    logic [7:0]  dataFont;

    int errors = 0;
    int checks = 0;

    memory_controller dut (
        .clk      (clk),
        .rst      (rst),
        .addrW    (addrW),
        .dataW    (dataW),
        .addrRChar(addrRChar),
        .addrRFont(addrRFont),
        .dataChar (dataChar),
        .dataFont (dataFont)
    );

    always #5 clk = ~clk;

    // Reference model: byte arrays for each region plus a LAT-deep queue of
    // pending read results per port.
    logic [7:0] charModel [8192];
    logic [7:0] fontModel [4096];
    logic [7:0] pipeC [LAT];
    logic [7:0] pipeF [LAT];
    logic [15:0] fontOff;

    initial begin
        foreach (charModel[i]) charModel[i] = 8'h00;
        foreach (fontModel[i]) fontModel[i] = 8'h00;
    end

    assign fontOff = addrW - 16'h2000;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                pipeC[i] <= 8'h00;
                pipeF[i] <= 8'h00;
            end
        end else begin
            for (int i = 1; i < LAT; i++) begin
                pipeC[i] <= pipeC[i-1];
                pipeF[i] <= pipeF[i-1];
            end
            pipeC[0] <= charModel[addrRChar];
            pipeF[0] <= fontModel[addrRFont];
            if (addrW < 16'h2000)
                charModel[addrW[12:0]] <= dataW;
            else if (addrW < 16'h3000)
                fontModel[fontOff[11:0]] <= dataW;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [7:0] expC, expF;
        expC = rst ? 8'h00 : pipeC[LAT-1];
        expF = rst ? 8'h00 : pipeF[LAT-1];
        checks = checks + 1;
        if (dataChar !== expC) begin
            errors = errors + 1;
            $display("FAIL model_char t=%0t got=%h exp=%h", $time, dataChar, expC);
        end
        checks = checks + 1;
        if (dataFont !== expF) begin
            errors = errors + 1;
            $display("FAIL model_font t=%0t got=%h exp=%h", $time, dataFont, expF);
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, settle 2 ns past it.
    task automatic cyc(input logic [15:0] aw, input logic [7:0] dw,
                       input logic [12:0] rc, input logic [11:0] rf);
        addrW     = aw;
        dataW     = dw;
        addrRChar = rc;
        addrRFont = rf;
        @(posedge clk);
        #2;
    endtask

    // Parked cycles; parking data is nonzero so a leaky decode shows up.
    task automatic idle(input int n, input logic [12:0] rc, input logic [11:0] rf);
        for (int i = 0; i < n; i++) cyc(16'hFFFF, 8'hEE, rc, rf);
    endtask

    initial begin
        rst       = 1'b1;
        addrW     = 16'hFFFF;
        dataW     = 8'hEE;
        addrRChar = '0;
        addrRFont = '0;
        #102;
        rst = 1'b0;
        #1;
        chk("reset_char", dataChar, 8'h00);
        chk("reset_font", dataFont, 8'h00);
        idle(LAT, 13'd0, 12'd0);
        chk("first_read_char", dataChar, 8'h00);
        chk("first_read_font", dataFont, 8'h00);

        // Character write then read
        cyc(16'h0005, 8'hA5, 13'd0, 12'd0);
        idle(LAT, 13'd5, 12'd5);
        chk("char_rd", dataChar, 8'hA5);
        chk("char_font_untouched", dataFont, 8'h00);

        // Font write then read
        cyc(16'h2010, 8'h3C, 13'd0, 12'd0);
        idle(LAT, 13'h010, 12'h010);
        chk("font_rd", dataFont, 8'h3C);
        chk("font_char_untouched", dataChar, 8'h00);

        // Unmapped writes
        cyc(16'h3000, 8'hFF, 13'd0, 12'd0);
        cyc(16'h8000, 8'h77, 13'd0, 12'd0);
        idle(LAT, 13'd0, 12'd0);
        chk("unmapped_char", dataChar, 8'h00);
        chk("unmapped_font", dataFont, 8'h00);

        // Read-during-write, read-first
        cyc(16'h0007, 8'h11, 13'd0, 12'd0);
        cyc(16'h0007, 8'h22, 13'd7, 12'd0);
        idle(LAT - 1, 13'd7, 12'd0);
        chk("rdw_old", dataChar, 8'h11);
        idle(1, 13'd7, 12'd0);
        chk("rdw_new", dataChar, 8'h22);

        // Region boundaries, read concurrently
        cyc(16'h1FFF, 8'h5A, 13'd0, 12'd0);
        cyc(16'h2FFF, 8'hC3, 13'd0, 12'd0);
        idle(1, 13'h1FFF, 12'hFFF);
        if (LAT == 2) begin
            chk("bound_char_early", dataChar, 8'h00);
            chk("bound_font_early", dataFont, 8'h00);
        end
        idle(LAT - 1, 13'h1FFF, 12'hFFF);
        chk("bound_char", dataChar, 8'h5A);
        chk("bound_font", dataFont, 8'hC3);

        // Short mixed sweep checked only by the model
        cyc(16'h0100, 8'h81, 13'h1FFF, 12'h010);
        cyc(16'h2100, 8'h42, 13'h0100, 12'hFFF);
        cyc(16'h0101, 8'h9D, 13'h0100, 12'h100);
        cyc(16'h2100, 8'h24, 13'h0101, 12'h100);
        idle(3, 13'h0101, 12'h100);

        // Asynchronous reset with nonzero outputs
        idle(LAT, 13'd5, 12'h010);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_char", dataChar, 8'h00);
        chk("async_rst_font", dataFont, 8'h00);
        cyc(16'h0200, 8'h77, 13'd5, 12'h010);
        chk("rst_hold_char", dataChar, 8'h00);
        chk("rst_hold_font", dataFont, 8'h00);
        rst = 1'b0;
        idle(LAT, 13'h0200, 12'h010);
        chk("rst_write_blocked", dataChar, 8'h00);
        chk("rst_keeps_font", dataFont, 8'h3C);
        idle(LAT, 13'd5, 12'h010);
        chk("rst_keeps_char", dataChar, 8'hA5);

        idle(2, 13'd0, 12'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
